gpr_file: RTL and testbench

- Architectural general-purpose register file for the NPC core. It is the consuming end of the writeback register interface (`wena`/`waddr`/`wdata`).
- Provides two combinational read ports to the decode stage.
- Holds a per-register busy scoreboard. Issue sets a register's busy bit and writeback clears it, so decode can stall on read-after-write hazards.
- Register x0 is hardwired to zero and is never marked busy.

---
 rtl/gpr_file_pkg.sv | 13 +
 rtl/gpr_scoreboard.sv | 46 ++++
 rtl/gpr_file.sv | 93 +++++++++
 tb/tb_gpr_file.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_file_pkg.sv
// gpr_file_pkg: shared constants for the NPC general-purpose register file.
// Holds the register-bus widths, the register count, the hardwired-zero index
// and the reset-active level of this block.
package gpr_file_pkg;

  localparam int REG_ADDR_BUS = 5;                  // register index width
  localparam int REG_DATA_BUS = 32;                 // register data width
  localparam int GPR_NUM      = 2 ** REG_ADDR_BUS;  // architectural register count
  localparam int GPR_ZERO_IDX = 0;                  // x0, hardwired to zero

  localparam logic RST_ENABLE = 1'b1;               // this block resets on rst high

endpackage : gpr_file_pkg

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register busy bits for read-after-write hazard detection.
//   clk, rst         : clock, asynchronous active-high reset
//   set_en, set_idx  : issue of an instruction that writes set_idx (idx != 0)
//   clr_en, clr_idx  : writeback to clr_idx (idx != 0)
//   flush            : clears every busy bit, overriding a same-cycle set
//   raddr1, raddr2   : read-port indices
//   busy1, busy2     : busy bit of each read index, 0 for x0
module gpr_scoreboard
  import gpr_file_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_BUS,
  parameter int NUM_REGS = GPR_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic              flush,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              busy1,
  output logic              busy2
);

  logic [NUM_REGS-1:0] busy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; here the later set also overrides the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      // Set is issued by a younger instruction, so it wins a same-index clear.
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

  assign busy1 = (raddr1 != ADDR_W'(GPR_ZERO_IDX)) & busy[raddr1];
  assign busy2 = (raddr2 != ADDR_W'(GPR_ZERO_IDX)) & busy[raddr2];

endmodule : gpr_scoreboard

// File: rtl/gpr_file.sv
// gpr_file: architectural register file of the NPC core with busy scoreboard.
//   clk, rst                        : clock, asynchronous active-high reset
//   wena_i, waddr_i, wdata_i        : writeback port (also clears busy)
//   issue_valid_i/wena_i/rd_i       : issue port (sets busy of rd)
//   flush_i                         : clears all busy bits
//   raddr1_i/raddr2_i               : combinational read indices
//   rdata1_o/rdata2_o               : read data, 0 for x0
//   busy1_o/busy2_o                 : pending-write flag per read index
// Build option: define GPR_FILE_BYPASS_EN to forward same-cycle writeback data
// to the read ports (and report not-busy for the forwarded index).
module gpr_file
  import gpr_file_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_BUS,
  parameter int DATA_W   = REG_DATA_BUS,
  parameter int NUM_REGS = GPR_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wena_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              issue_valid_i,
  input  logic              issue_wena_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic              busy1_o,
  output logic              busy2_o
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(GPR_ZERO_IDX);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;
  logic              set_en;
  logic              sb_busy1;
  logic              sb_busy2;

  assign wr_en  = wena_i & (waddr_i != ZERO_IDX);
  assign set_en = issue_valid_i & issue_wena_i & (issue_rd_i != ZERO_IDX);

  // NOTE: the data array is reset because architectural state must read zero
  // while rst is held; this rules out a plain RAM macro for this array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  gpr_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_idx (issue_rd_i),
    .clr_en  (wr_en),
    .clr_idx (waddr_i),
    .flush   (flush_i),
    .raddr1  (raddr1_i),
    .raddr2  (raddr2_i),
    .busy1   (sb_busy1),
    .busy2   (sb_busy2)
  );

  // NOTE: every output gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata1_o = (raddr1_i == ZERO_IDX) ? '0 : regs[raddr1_i];
    rdata2_o = (raddr2_i == ZERO_IDX) ? '0 : regs[raddr2_i];
    busy1_o  = sb_busy1;
    busy2_o  = sb_busy2;
`ifdef GPR_FILE_BYPASS_EN
    // The in-flight writeback already carries the value decode is waiting for.
    if (wr_en && (waddr_i == raddr1_i)) begin
      rdata1_o = wdata_i;
      busy1_o  = 1'b0;
    end
    if (wr_en && (waddr_i == raddr2_i)) begin
      rdata2_o = wdata_i;
      busy2_o  = 1'b0;
    end
`endif
  end

endmodule : gpr_file

// File: tb/tb_gpr_file.sv
`timescale 1ns / 100ps
module tb_gpr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wena;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        issue_valid;
  logic        issue_wena;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        busy1;
  logic        busy2;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural contents and pending-write flags.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  gpr_file dut (
    .clk           (clk),
    .rst           (rst),
    .wena_i        (wena),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .issue_valid_i (issue_valid),
    .issue_wena_i  (issue_wena),
    .issue_rd_i    (issue_rd),
    .flush_i       (flush),
    .raddr1_i      (raddr1),
    .raddr2_i      (raddr2),
    .rdata1_o      (rdata1),
    .rdata2_o      (rdata2),
    .busy1_o       (busy1),
    .busy2_o       (busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef GPR_FILE_BYPASS_EN
    if (wena && waddr == a) return wdata;
`endif
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef GPR_FILE_BYPASS_EN
    if (wena && waddr == a) return 32'h0;
`endif
    return {31'h0, m_busy[a]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_rdata1"}, rdata1, exp_rdata(raddr1));
    check({tag, "_rdata2"}, rdata2, exp_rdata(raddr2));
    check({tag, "_busy1"}, {31'h0, busy1}, exp_busy(raddr1));
    check({tag, "_busy2"}, {31'h0, busy2}, exp_busy(raddr2));
  endtask

  // Apply one cycle's inputs away from the rising edge and check the reads.
  task automatic drive(input string tag, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic iv, input logic iw,
                       input logic [4:0] rd, input logic fl,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    wena = we; waddr = wa; wdata = wd;
    issue_valid = iv; issue_wena = iw; issue_rd = rd;
    flush = fl; raddr1 = r1; raddr2 = r2;
    #1;
    check_reads(tag);
  endtask

  // Advance one rising edge and apply the architectural rules to the model.
  task automatic tick();
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (wena && waddr != 0) m_busy[waddr] = 1'b0;
      if (issue_valid && issue_wena && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
    if (wena && waddr != 0) m_regs[waddr] = wdata;
  endtask

  task automatic idle(input string tag, input logic [4:0] r1, input logic [4:0] r2);
    drive(tag, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, r1, r2);
  endtask

  function automatic logic [4:0] rand_addr();
    // Bias toward a few low indices so hazards and collisions occur often.
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst = 1'b1;
    wena = 0; waddr = 0; wdata = 0;
    issue_valid = 0; issue_wena = 0; issue_rd = 0;
    flush = 0; raddr1 = 0; raddr2 = 0;
    model_reset();

    // 1. Reset held, no clock edge yet: every address reads zero and not busy.
    #1;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #0.1;
      check_reads("reset");
    end
    @(negedge clk);
    rst = 1'b0;

    // 2. Write then read.
    drive("wr", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
`ifdef GPR_FILE_BYPASS_EN
    check("wr_same_cycle", rdata1, 32'hDEADBEEF);
`else
    check("wr_same_cycle", rdata1, 32'h0);
`endif
    tick();
    idle("wr_next", 5'd5, 5'd5);
    check("wr_next_value", rdata1, 32'hDEADBEEF);
    tick();

    // 3. x0 protection for data and scoreboard.
    drive("x0", 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    idle("x0_after", 5'd0, 5'd0);
    check("x0_rdata", rdata1, 32'h0);
    check("x0_busy", {31'h0, busy1}, 32'h0);
    tick();

    // 4. Scoreboard lifecycle on x7.
    drive("iss7", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
    tick();
    idle("busy7", 5'd7, 5'd0);
    check("busy7_set", {31'h0, busy1}, 32'h1);
    tick();
    drive("wb7", 1'b1, 5'd7, 32'h0000_0777, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
    tick();
    idle("clr7", 5'd7, 5'd0);
    check("busy7_clr", {31'h0, busy1}, 32'h0);
    check("x7_data", rdata1, 32'h0000_0777);
    tick();

    // 5. Set and clear collide on x3: set wins, data still written.
    drive("iss3", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd3, 5'd0);
    tick();
    drive("coll3", 1'b1, 5'd3, 32'h12, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 5'd3);
    tick();
    idle("coll3_after", 5'd3, 5'd3);
    check("coll3_busy", {31'h0, busy1}, 32'h1);
    check("coll3_data", rdata1, 32'h12);
    tick();

    // 6a. Flush beats a same-cycle issue.
    drive("iss4", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd4, 1'b0, 5'd4, 5'd9);
    tick();
    drive("iss9", 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd4, 5'd9);
    tick();
    idle("pre_flush", 5'd4, 5'd9);
    check("busy4_pre", {31'h0, busy1}, 32'h1);
    check("busy9_pre", {31'h0, busy2}, 32'h1);
    tick();
    drive("flush", 1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 5'd4, 1'b1, 5'd4, 5'd9);
    tick();
    for (int i = 0; i < 32; i += 2) begin
      idle("post_flush", 5'(i), 5'(i + 1));
      tick();
    end
    idle("flush_data", 5'd9, 5'd4);
    check("flush_wr9", rdata1, 32'h99);
    check("flush_busy4", {31'h0, busy2}, 32'h0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive("rand",
            1'($urandom_range(0, 1)), rand_addr(), $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), rand_addr(),
            1'($urandom_range(0, 19) == 0), rand_addr(), rand_addr());
      tick();
    end

    // 6b. Asynchronous reset between edges clears everything at once.
    @(negedge clk);
    wena = 0; issue_valid = 0; flush = 0;
    #2;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(i);
      #0.1;
      check("async_rst_rdata", rdata1, 32'h0);
      check("async_rst_busy", {31'h0, busy2}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_gpr_file
